// File: rtl/snail_seq_gen.sv
// snail_seq_gen
// Serial pattern generator feeding the A input of the snail sequence
// detector. A WIDTH-bit pattern is captured on an accepted start and shifted
// out MSB first, one bit per clock, with a start/busy/done handshake.
//
// Build option: define SNAIL_SEQ_GEN_LOOP_EN to repeat the captured pattern
// continuously. Only abort or rst leave the stream in that build.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    frame request, sampled in IDLE or DONE only
//   abort    synchronous terminate, highest priority, no done pulse
//   pattern  frame data, captured on the accepted start edge
//   A        registered serial bit, MSB first
//   valid    A carries a pattern bit this cycle
//   busy     frame in progress
//   done     one-cycle pulse after the last bit
//   bit_idx  pattern index currently on A
module snail_seq_gen #(
    parameter int WIDTH = 24,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    output logic             A,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] bit_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
`ifdef SNAIL_SEQ_GEN_LOOP_EN
    // Private copy of the frame so a reload never looks at the live port.
    logic [WIDTH-1:0] cap_q, cap_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef SNAIL_SEQ_GEN_LOOP_EN
            cap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
`ifdef SNAIL_SEQ_GEN_LOOP_EN
            cap_q   <= cap_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
`ifdef SNAIL_SEQ_GEN_LOOP_EN
        cap_d   = cap_q;
`endif
        if (abort) begin
            state_d = ST_IDLE;
            shreg_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_SHIFT;
                        shreg_d = pattern;
                        cnt_d   = LAST_IDX;
                        valid_d = 1'b1;
`ifdef SNAIL_SEQ_GEN_LOOP_EN
                        cap_d   = pattern;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == '0) begin
`ifdef SNAIL_SEQ_GEN_LOOP_EN
                        // Seamless restart: done marks the new MSB.
                        shreg_d = cap_q;
                        cnt_d   = LAST_IDX;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
`else
                        // Clearing the shifter forces A low in DONE.
                        state_d = ST_DONE;
                        shreg_d = '0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q - IDX_W'(1);
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    shreg_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Every output comes straight from a flop; busy and valid coincide.
    assign A       = shreg_q[WIDTH-1];
    assign valid   = valid_q;
    assign busy    = valid_q;
    assign done    = done_q;
    assign bit_idx = cnt_q;

endmodule

// File: tb/tb_snail_seq_gen.sv
module tb_snail_seq_gen;

    localparam int W  = 24;
    localparam int IW = $clog2(W);

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          start   = 1'b0;
    logic          abort   = 1'b0;
    logic [W-1:0]  pattern = '0;
    logic          A, valid, busy, done;
    logic [IW-1:0] bit_idx;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    // Expected per-cycle outputs {A,valid,busy,done,bit_idx} tagged with the
    // cycle number (edges since time 0) at which they must be visible.
    typedef struct {
        int            c;
        logic [IW+3:0] v;
    } exp_t;
    exp_t q[$];

    snail_seq_gen #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .pattern (pattern),
        .A       (A),
        .valid   (valid),
        .busy    (busy),
        .done    (done),
        .bit_idx (bit_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [IW+3:0] act, input logic [IW+3:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got A,valid,busy,done,idx=%b required %b", nm, cyc, act, req);
        end
    endtask

    function automatic void push(input int c, input logic a, input logic vb, input logic d,
                                 input logic [IW-1:0] idx);
        exp_t e;
        e.c = c;
        e.v = {a, vb, vb, d, idx};
        q.push_back(e);
    endfunction

    // Single-shot reference: bit k of the frame shows after edge e0+k, done
    // one cycle after the LSB; an abort at edge e0+ab truncates the frame.
    function automatic void model_frame(input logic [W-1:0] pat, input int e0, input int ab);
        int n;
        n = (ab == 0) ? W : ab;
        for (int k = 0; k < n; k++)
            push(e0 + k, pat[W-1-k], 1'b1, 1'b0, IW'(W - 1 - k));
        if (ab == 0)
            push(e0 + W, 1'b0, 1'b0, 1'b1, '0);
    endfunction

    // Looping reference: an endless repetition of the pattern, done marking
    // every MSB but the first, cut by abort after 'total' bits.
    function automatic void model_loop(input logic [W-1:0] pat, input int e0, input int total);
        int j;
        for (int k = 0; k < total; k++) begin
            j = k % W;
            push(e0 + k, pat[W-1-j], 1'b1, (k >= W) && (j == 0), IW'(W - 1 - j));
        end
    endfunction

    // Monitor: every cycle either pops the entry due now or demands silence.
    always @(negedge clk) begin : monitor
        logic [IW+3:0] act;
        exp_t          e;
        act = {A, valid, busy, done, bit_idx};
        if (q.size() > 0 && q[0].c == cyc) begin
            e = q.pop_front();
            check("stream", act, e.v);
        end else begin
            check("quiet", act, '0);
        end
    end

    // smode: start level during the frame (0 low, 1 held high, 2 random).
    // Called and returning on a falling edge; a following call is back-to-back.
    task automatic frame(input logic [W-1:0] pat, input int ab, input int smode,
                         input logic [W-1:0] pat_after);
        int e0, n;
        e0      = cyc + 1;
        start   = 1'b1;
        pattern = pat;
        model_frame(pat, e0, ab);
        n = (ab == 0) ? W : ab;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            start   = (smode == 2) ? 1'($urandom) : (smode == 1);
            pattern = (smode == 2) ? W'($urandom) : pat_after;
            abort   = (ab == k);
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic loop_run(input logic [W-1:0] pat, input int total);
        int e0;
        e0      = cyc + 1;
        start   = 1'b1;
        pattern = pat;
        model_loop(pat, e0, total);
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            start   = 1'($urandom);
            pattern = W'($urandom);
            abort   = (k == total);
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Start a frame, let 'at' bits out, then hit rst between clock edges.
    task automatic reset_mid(input logic [W-1:0] pat, input int at);
        int e0;
        e0      = cyc + 1;
        start   = 1'b1;
        pattern = pat;
        model_frame(pat, e0, at);
        repeat (at) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1 check("async_reset", {A, valid, busy, done, bit_idx}, '0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stim
        logic [W-1:0] pat;
        int           ab;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", {A, valid, busy, done, bit_idx}, '0);
        rst = 1'b0;
        @(negedge clk);
`ifndef SNAIL_SEQ_GEN_LOOP_EN
        frame(24'hE34EED, 0, 0, 24'hE34EED);
        repeat (3) @(negedge clk);
        frame(24'hFFFFFF, 0, 0, 24'h000000);
        @(negedge clk);
        repeat (3) frame(24'hAAAAAA, 0, 1, 24'hAAAAAA);
        @(negedge clk);
        frame(24'hE34EED, 14, 0, 24'hE34EED);
        repeat (2) @(negedge clk);
        frame(24'hE34EED, 0, 0, 24'h123456);
        @(negedge clk);
        reset_mid(24'hE34EED, 6);
        @(negedge clk);
        frame(24'h5A5A5A, W, 0, 24'h5A5A5A);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            pat = W'($urandom);
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
            frame(pat, ab, 2, '0);
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) @(negedge clk);
        end
`else
        loop_run(24'hE34EED, 3 * W);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            loop_run(W'($urandom), int'($urandom_range(1, 3 * W)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        reset_mid(24'hE34EED, 6);
        @(negedge clk);
`endif
        repeat (4) @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: %0d expected entries left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
